// File: rtl/shift_unit_pipelined.sv
// Pipelined N-bit shifter (SLL/SRL/SRA/ROL), one 2^k shift/rotate level per stage, LSB shamt bit first.
// Latency L = $clog2(N) registers; a stalled output freezes every stage and drops in_ready in the same cycle.
module shift_unit_pipelined #(
    parameter  int N = 32,
    localparam int L = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [L-1:0] in_shamt,
    input  logic [1:0]   in_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data
);

    logic advance;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // SRA fills from the carried sign bit rather than the current MSB.
    function automatic logic [N-1:0] step(input logic [N-1:0] d, input logic [1:0] op,
                                          input logic sign, input int amt);
        logic [N-1:0] fill;
        fill = sign ? ~({N{1'b1}} >> amt) : '0;
        case (op)
            2'b00:   step = d << amt;
            2'b01:   step = d >> amt;
            2'b10:   step = (d >> amt) | fill;
            default: step = (d << amt) | (d >> (N - amt));
        endcase
    endfunction

    for (genvar k = 0; k < L; k++) begin : stg
        localparam int W = L - k;

        logic         pv;
        logic [N-1:0] pd;
        logic [1:0]   pop;
        logic         psg;
        logic [W-1:0] psh;
        logic         v_q;
        logic [N-1:0] d_q;

        if (k == 0) begin : src
            assign pv  = in_valid & in_ready;
            assign pd  = in_data;
            assign pop = in_op;
            assign psg = in_data[N-1];
            assign psh = in_shamt;
        end else begin : src
            assign pv  = stg[k-1].v_q;
            assign pd  = stg[k-1].d_q;
            assign pop = stg[k-1].carry.op_q;
            assign psg = stg[k-1].carry.sg_q;
            assign psh = stg[k-1].carry.sh_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
            end else if (advance) begin
                v_q <= pv;
                d_q <= psh[0] ? step(pd, pop, psg, 1 << k) : pd;
            end
        end

        // The final stage has no successor, so it keeps only valid and data.
        if (k < L - 1) begin : carry
            logic [1:0]   op_q;
            logic         sg_q;
            logic [W-2:0] sh_q;

            always_ff @(posedge clk) begin
                if (advance) begin
                    op_q <= pop;
                    sg_q <= psg;
                    sh_q <= psh[W-1:1];
                end
            end
        end
    end

    assign out_valid = stg[L-1].v_q;
    assign out_data  = stg[L-1].d_q;

endmodule
